// File: rtl/spmv_row_dot_lanes_if.sv
// rtl/spmv_row_dot_lanes_if.sv - count, value, X and Y stream bundle for the row dot-product engine
interface spmv_row_dot_lanes_if #(
    parameter int LANES  = 4,
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 32
);
    logic [CNT_W-1:0]        s_times_tdata;
    logic                    s_times_tvalid;
    logic                    s_times_tready;
    logic [LANES*DATA_W-1:0] s_val_tdata;
    logic                    s_val_tvalid;
    logic                    s_val_tready;
    logic [LANES*DATA_W-1:0] s_xi_tdata;
    logic                    s_xi_tvalid;
    logic                    s_xi_tready;
    logic [ACC_W-1:0]        m_y_tdata;
    logic                    m_y_tvalid;
    logic                    m_y_tready;

    modport slave (
        input  s_times_tdata, s_times_tvalid,
        output s_times_tready,
        input  s_val_tdata, s_val_tvalid,
        output s_val_tready,
        input  s_xi_tdata, s_xi_tvalid,
        output s_xi_tready,
        output m_y_tdata, m_y_tvalid,
        input  m_y_tready
    );

    modport master (
        output s_times_tdata, s_times_tvalid,
        input  s_times_tready,
        output s_val_tdata, s_val_tvalid,
        input  s_val_tready,
        output s_xi_tdata, s_xi_tvalid,
        input  s_xi_tready,
        input  m_y_tdata, m_y_tvalid,
        output m_y_tready
    );
endinterface

// File: rtl/spmv_row_dot_lanes.sv
// rtl/spmv_row_dot_lanes.sv - multi-lane signed row dot-product with lane masking and optional saturation
module spmv_row_dot_lanes #(
    parameter int LANES    = 4,
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 48,
    parameter int CNT_W    = 32,
    parameter int SATURATE = 0
) (
    input  logic                clk,
    input  logic                rst,
    spmv_row_dot_lanes_if.slave bus,
    output logic [31:0]         rows_done,
    output logic                sat_flag
);
    localparam int SUM_W  = ACC_W + $clog2(LANES) + 1;
    localparam int PROD_W = 2 * DATA_W;
    localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, EMIT} state_t;
    state_t state, state_next;

    logic [ACC_W-1:0]         acc, acc_next, y_data;
    logic [CNT_W-1:0]         rem;
    logic                     last_beat, clamp_hit;
    logic                     count_fire, beat_fire, y_fire;
    logic signed [SUM_W-1:0]  sum;
    logic signed [PROD_W-1:0] a_ext, b_ext, prod;

    assign last_beat     = (rem <= CNT_W'(LANES));
    assign bus.m_y_tdata = y_data;

    // EMIT lets a new count through in the same cycle Y is taken
    always_comb begin
        state_next         = state;
        bus.s_times_tready = 1'b0;
        bus.s_val_tready   = 1'b0;
        bus.s_xi_tready    = 1'b0;
        bus.m_y_tvalid     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE:    bus.s_times_tready = 1'b1;
                ACCUM: begin
                    bus.s_val_tready = bus.s_val_tvalid & bus.s_xi_tvalid;
                    bus.s_xi_tready  = bus.s_val_tvalid & bus.s_xi_tvalid;
                end
                EMIT: begin
                    bus.m_y_tvalid     = 1'b1;
                    bus.s_times_tready = bus.m_y_tready;
                end
                default: ;
            endcase
        end
        count_fire = bus.s_times_tvalid & bus.s_times_tready;
        beat_fire  = bus.s_val_tready;
        y_fire     = bus.m_y_tvalid & bus.m_y_tready;
        case (state)
            IDLE:    if (count_fire) state_next = (bus.s_times_tdata == '0) ? EMIT : ACCUM;
            ACCUM:   if (beat_fire && last_beat) state_next = EMIT;
            EMIT: begin
                if (y_fire) begin
                    if (!count_fire)                   state_next = IDLE;
                    else if (bus.s_times_tdata == '0)  state_next = EMIT;
                    else                               state_next = ACCUM;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Lanes at or beyond the remaining count are masked so the tail beat's padding is ignored
    always_comb begin
        sum   = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
        a_ext = '0;
        b_ext = '0;
        prod  = '0;
        for (int i = 0; i < LANES; i++) begin
            a_ext = {{DATA_W{bus.s_val_tdata[i*DATA_W+DATA_W-1]}}, bus.s_val_tdata[i*DATA_W +: DATA_W]};
            b_ext = {{DATA_W{bus.s_xi_tdata[i*DATA_W+DATA_W-1]}}, bus.s_xi_tdata[i*DATA_W +: DATA_W]};
            prod  = a_ext * b_ext;
            if (CNT_W'(i) < rem)
                sum = sum + {{(SUM_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
        clamp_hit = 1'b0;
        acc_next  = sum[ACC_W-1:0];
        if (SATURATE != 0) begin
            if (sum > ACC_MAX) begin
                acc_next  = ACC_MAX[ACC_W-1:0];
                clamp_hit = 1'b1;
            end else if (sum < ACC_MIN) begin
                acc_next  = ACC_MIN[ACC_W-1:0];
                clamp_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            rem       <= '0;
            y_data    <= '0;
            rows_done <= '0;
            sat_flag  <= 1'b0;
        end else begin
            if (count_fire) begin
                acc <= '0;
                rem <= bus.s_times_tdata;
                if (bus.s_times_tdata == '0) y_data <= '0;
            end else if (beat_fire) begin
                acc <= acc_next;
                rem <= last_beat ? '0 : rem - CNT_W'(LANES);
                if (last_beat) y_data <= acc_next;
                if (clamp_hit) sat_flag <= 1'b1;
            end
            if (y_fire) rows_done <= rows_done + 32'd1;
        end
    end
endmodule

// File: tb/tb_spmv_row_dot_lanes.sv
// tb/tb_spmv_row_dot_lanes.sv - table, sequence and randomized checks of the row dot-product engine
module tb_spmv_row_dot_lanes;
    localparam int LANES  = 4;
    localparam int DATA_W = 16;
    localparam int ACC_W  = 48;
    localparam int CNT_W  = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spmv_row_dot_lanes_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    spmv_row_dot_lanes_if #(.LANES(4), .DATA_W(16), .ACC_W(32), .CNT_W(32)) bus_s ();
    spmv_row_dot_lanes_if #(.LANES(4), .DATA_W(16), .ACC_W(32), .CNT_W(32)) bus_w ();
    logic [31:0] rows_done, rows_done_s, rows_done_w;
    logic        sat_flag, sat_flag_s, sat_flag_w;

    spmv_row_dot_lanes #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W), .SATURATE(0)) dut (
        .clk(clk), .rst(rst), .bus(bus), .rows_done(rows_done), .sat_flag(sat_flag));
    spmv_row_dot_lanes #(.LANES(4), .DATA_W(16), .ACC_W(32), .CNT_W(32), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .bus(bus_s), .rows_done(rows_done_s), .sat_flag(sat_flag_s));
    spmv_row_dot_lanes #(.LANES(4), .DATA_W(16), .ACC_W(32), .CNT_W(32), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus_w), .rows_done(rows_done_w), .sat_flag(sat_flag_w));

    // The wrapping instance sees exactly the saturating instance's stimulus
    assign bus_w.s_times_tdata  = bus_s.s_times_tdata;
    assign bus_w.s_times_tvalid = bus_s.s_times_tvalid;
    assign bus_w.s_val_tdata    = bus_s.s_val_tdata;
    assign bus_w.s_val_tvalid   = bus_s.s_val_tvalid;
    assign bus_w.s_xi_tdata     = bus_s.s_xi_tdata;
    assign bus_w.s_xi_tvalid    = bus_s.s_xi_tvalid;
    assign bus_w.m_y_tready     = bus_s.m_y_tready;

    typedef struct {
        int          n;
        logic [63:0] v0, v1, x0, x1;
        longint      y;
    } vec_t;

    int          vectors = 0;
    int          miscompares = 0;
    int          rows_exp = 0;
    logic [63:0] beat_val [8];
    logic [63:0] beat_xi  [8];
    vec_t        tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [63:0] m48(input longint v);
        logic [63:0] t;
        t = 64'(v);
        return {16'h0, t[47:0]};
    endfunction

    function automatic vec_t mk(input int n, input logic [63:0] v0, input logic [63:0] v1,
                                input logic [63:0] x0, input logic [63:0] x1, input longint y);
        vec_t r;
        r.n = n; r.v0 = v0; r.v1 = v1; r.x0 = x0; r.x1 = x1; r.y = y;
        return r;
    endfunction

    task automatic run_row(input string name, input int n, input longint exp_y, input int gap, input int bp);
        int          beats, b;
        bit          ok, seen, stable_err, ready_err, extra_beat;
        logic [47:0] y_seen;
        beats = (n + LANES - 1) / LANES;
        bus.s_times_tdata  = 32'(n);
        bus.s_times_tvalid = 1'b1;
        ok = 0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = bus.s_times_tready;
            nxt();
        end
        bus.s_times_tvalid = 1'b0;
        check({name, " count accepted"}, 64'(ok), 64'd1);
        b = 0;
        ready_err = 0;
        for (int t = 0; t < 400 && b < beats; t++) begin
            bus.s_val_tdata  = beat_val[b];
            bus.s_xi_tdata   = beat_xi[b];
            bus.s_val_tvalid = ($urandom_range(99) >= gap);
            bus.s_xi_tvalid  = ($urandom_range(99) >= gap);
            @(negedge clk);
            if (bus.s_val_tready !== (bus.s_val_tvalid & bus.s_xi_tvalid) || bus.s_xi_tready !== bus.s_val_tready)
                ready_err = 1;
            if (bus.s_val_tready) b++;
            nxt();
        end
        check({name, " beats consumed"}, 64'(b), 64'(beats));
        bus.s_val_tvalid = 1'b1;
        bus.s_xi_tvalid  = 1'b1;
        bus.s_val_tdata  = {$urandom(), $urandom()};
        bus.s_xi_tdata   = {$urandom(), $urandom()};
        ok = 0; seen = 0; stable_err = 0; extra_beat = 0;
        y_seen = '0;
        for (int t = 0; t < 100 && !ok; t++) begin
            bus.m_y_tready = ($urandom_range(99) >= bp);
            @(negedge clk);
            if (bus.s_val_tready || bus.s_xi_tready) extra_beat = 1;
            if (bus.m_y_tvalid) begin
                if (seen && bus.m_y_tdata !== y_seen) stable_err = 1;
                if (bus.s_times_tready !== bus.m_y_tready) ready_err = 1;
                seen   = 1;
                y_seen = bus.m_y_tdata;
                ok     = bus.m_y_tready;
            end
            nxt();
        end
        bus.m_y_tready   = 1'b0;
        bus.s_val_tvalid = 1'b0;
        bus.s_xi_tvalid  = 1'b0;
        rows_exp++;
        check({name, " y accepted"}, 64'(ok), 64'd1);
        check({name, " y"}, 64'(y_seen), m48(exp_y));
        check({name, " y stable"}, 64'(stable_err), 64'd0);
        check({name, " ready rules"}, 64'(ready_err), 64'd0);
        check({name, " extra beat"}, 64'(extra_beat), 64'd0);
        check({name, " rows_done"}, 64'(rows_done), 64'(rows_exp));
    endtask

    task automatic sat_row(input int n, input logic [63:0] v, input logic [63:0] x, input int beats,
                           output logic [31:0] ys, output logic [31:0] yw, output bit ok);
        int b;
        bit got;
        ok = 0; got = 0; ys = '0; yw = '0;
        bus_s.s_times_tdata  = 32'(n);
        bus_s.s_times_tvalid = 1'b1;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            ok = bus_s.s_times_tready;
            nxt();
        end
        bus_s.s_times_tvalid = 1'b0;
        bus_s.s_val_tdata  = v;
        bus_s.s_xi_tdata   = x;
        bus_s.s_val_tvalid = 1'b1;
        bus_s.s_xi_tvalid  = 1'b1;
        b = 0;
        for (int t = 0; t < 50 && b < beats; t++) begin
            @(negedge clk);
            if (bus_s.s_val_tready) b++;
            nxt();
        end
        bus_s.s_val_tvalid = 1'b0;
        bus_s.s_xi_tvalid  = 1'b0;
        bus_s.m_y_tready   = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            if (bus_s.m_y_tvalid && bus_w.m_y_tvalid) begin
                got = 1;
                ys  = bus_s.m_y_tdata;
                yw  = bus_w.m_y_tdata;
            end
            nxt();
        end
        bus_s.m_y_tready = 1'b0;
        ok = ok && got && (b == beats);
    endtask

    task automatic back_to_back();
        int     cf [2];
        int     yf [2];
        longint yv [2];
        int     nc, ny;
        nc = 0; ny = 0;
        cf = '{-100, -100}; yf = '{-100, -100}; yv = '{0, 0};
        bus.s_val_tdata    = pack4(1, 1, 1, 1);
        bus.s_xi_tdata     = pack4(3, 3, 3, 3);
        bus.s_val_tvalid   = 1'b1;
        bus.s_xi_tvalid    = 1'b1;
        bus.m_y_tready     = 1'b1;
        bus.s_times_tdata  = 32'd4;
        bus.s_times_tvalid = 1'b1;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (bus.s_times_tvalid && bus.s_times_tready && nc < 2) begin cf[nc] = cyc; nc++; end
            if (bus.m_y_tvalid && bus.m_y_tready && ny < 2) begin yf[ny] = cyc; yv[ny] = longint'(bus.m_y_tdata); ny++; end
            nxt();
            if (nc == 2) bus.s_times_tvalid = 1'b0;
        end
        bus.s_val_tvalid = 1'b0;
        bus.s_xi_tvalid  = 1'b0;
        bus.m_y_tready   = 1'b0;
        rows_exp += 2;
        check("b2b counts", 64'(nc), 64'd2);
        check("b2b results", 64'(ny), 64'd2);
        check("b2b y0", 64'(yv[0]), 64'd12);
        check("b2b y1", 64'(yv[1]), 64'd12);
        check("b2b overlap", 64'(cf[1] - yf[0]), 64'd0);
        check("b2b first latency", 64'(yf[0] - cf[0]), 64'd2);
        check("b2b second latency", 64'(yf[1] - cf[0]), 64'd4);
        check("b2b rows_done", 64'(rows_done), 64'(rows_exp));
    endtask

    task automatic backpressure();
        bit err;
        int r;
        err = 0;
        bus.m_y_tready     = 1'b0;
        bus.s_val_tdata    = pack4(1, 1, 1, 1);
        bus.s_xi_tdata     = pack4(3, 3, 3, 3);
        bus.s_times_tdata  = 32'd4;
        bus.s_times_tvalid = 1'b1;
        @(negedge clk);
        check("bp count", 64'(bus.s_times_tready), 64'd1);
        nxt();
        bus.s_times_tvalid = 1'b0;
        for (int t = 0; t < 6; t++) begin
            bus.s_val_tvalid = (t < 3);
            bus.s_xi_tvalid  = (t >= 3);
            @(negedge clk);
            if (bus.s_val_tready || bus.s_xi_tready) err = 1;
            nxt();
        end
        check("one-sided valid", 64'(err), 64'd0);
        bus.s_val_tvalid = 1'b1;
        bus.s_xi_tvalid  = 1'b1;
        @(negedge clk);
        check("joint beat", 64'(bus.s_val_tready & bus.s_xi_tready), 64'd1);
        nxt();
        bus.s_times_tdata  = 32'd0;
        bus.s_times_tvalid = 1'b1;
        r = int'(rows_done);
        err = 0;
        for (int t = 0; t < 10; t++) begin
            bus.s_val_tdata = {$urandom(), $urandom()};
            @(negedge clk);
            if (!bus.m_y_tvalid || bus.m_y_tdata !== 48'd12 || bus.s_times_tready || bus.s_val_tready ||
                bus.s_xi_tready || rows_done !== 32'(r)) err = 1;
            nxt();
        end
        check("bp hold", 64'(err), 64'd0);
        bus.m_y_tready = 1'b1;
        @(negedge clk);
        check("bp release y", 64'(bus.m_y_tvalid), 64'd1);
        check("bp overlap count", 64'(bus.s_times_tready), 64'd1);
        nxt();
        bus.s_times_tvalid = 1'b0;
        rows_exp++;
        @(negedge clk);
        check("zero row valid", 64'(bus.m_y_tvalid), 64'd1);
        check("zero row y", 64'(bus.m_y_tdata), 64'd0);
        check("zero row no beat", 64'(bus.s_val_tready | bus.s_xi_tready), 64'd0);
        nxt();
        rows_exp++;
        bus.m_y_tready   = 1'b0;
        bus.s_val_tvalid = 1'b0;
        bus.s_xi_tvalid  = 1'b0;
        check("bp rows_done", 64'(rows_done), 64'(rows_exp));
    endtask

    initial begin
        logic [31:0] ys, yw;
        bit          ok;
        bus.s_times_tdata = '0; bus.s_times_tvalid = 1'b0;
        bus.s_val_tdata = '0;   bus.s_val_tvalid = 1'b0;
        bus.s_xi_tdata = '0;    bus.s_xi_tvalid = 1'b0;
        bus.m_y_tready = 1'b0;
        bus_s.s_times_tdata = '0; bus_s.s_times_tvalid = 1'b0;
        bus_s.s_val_tdata = '0;   bus_s.s_val_tvalid = 1'b0;
        bus_s.s_xi_tdata = '0;    bus_s.s_xi_tvalid = 1'b0;
        bus_s.m_y_tready = 1'b0;

        tbl[0] = mk(5, pack4(1, 2, 3, 4), pack4(5, 7, 7, 7), pack4(2, 2, 2, 2), pack4(2, 2, 2, 2), 30);
        tbl[1] = mk(4, pack4(-1, -2, -3, -4), pack4(9, 9, 9, 9), pack4(3, 3, 3, 3), pack4(9, 9, 9, 9), -30);
        tbl[2] = mk(1, pack4(-32768, 9, 9, 9), '0, pack4(-32768, 9, 9, 9), '0, 64'd1073741824);
        tbl[3] = mk(8, pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767),
                    pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768), -64'sd8589672448);
        tbl[4] = mk(3, pack4(100, 200, 300, 999), '0, pack4(1, -1, 2, 5), '0, 500);
        tbl[5] = mk(0, pack4(5, 5, 5, 5), '0, pack4(5, 5, 5, 5), '0, 0);
        tbl[6] = mk(7, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), pack4(1, 1, 1, 1), pack4(1, 1, 1, -100), 28);

        repeat (3) nxt();
        bus.s_val_tvalid = 1'b1;
        bus.s_xi_tvalid  = 1'b1;
        @(negedge clk);
        check("times ready in reset", 64'(bus.s_times_tready), 64'd0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        check("reset times ready", 64'(bus.s_times_tready), 64'd1);
        check("reset y valid", 64'(bus.m_y_tvalid), 64'd0);
        check("reset y data", 64'(bus.m_y_tdata), 64'd0);
        check("reset beat ready", 64'(bus.s_val_tready | bus.s_xi_tready), 64'd0);
        check("reset rows_done", 64'(rows_done), 64'd0);
        check("reset sat_flag", 64'(sat_flag | sat_flag_s), 64'd0);
        nxt();
        bus.s_val_tvalid = 1'b0;
        bus.s_xi_tvalid  = 1'b0;

        sat_row(8, pack4(32767, 32767, 32767, 32767), pack4(32767, 32767, 32767, 32767), 2, ys, yw, ok);
        check("sat row done", 64'(ok), 64'd1);
        check("sat y clamped", 64'(ys), 64'h7FFF_FFFF);
        check("wrap y", 64'(yw), 64'hFFF8_0008);
        check("sat flag set", 64'(sat_flag_s), 64'd1);
        check("wrap flag clear", 64'(sat_flag_w), 64'd0);
        sat_row(1, pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1, ys, yw, ok);
        check("sat second row done", 64'(ok), 64'd1);
        check("sat second y", 64'(ys), 64'd1);
        check("wrap second y", 64'(yw), 64'd1);
        check("sat flag sticky", 64'(sat_flag_s), 64'd1);
        check("sat rows_done", 64'(rows_done_s), 64'd2);

        for (int i = 0; i < 7; i++) begin
            beat_val[0] = tbl[i].v0; beat_val[1] = tbl[i].v1;
            beat_xi[0]  = tbl[i].x0; beat_xi[1]  = tbl[i].x1;
            run_row($sformatf("tbl%0d", i), tbl[i].n, tbl[i].y, 20, 20);
        end

        back_to_back();
        backpressure();

        for (int r = 0; r < 40; r++) begin
            int          n;
            longint      y;
            logic [15:0] v, x;
            n = int'($urandom_range(24));
            y = 0;
            for (int k = 0; k < 32; k++) begin
                v = 16'($urandom());
                x = 16'($urandom());
                beat_val[k / 4][(k % 4) * 16 +: 16] = v;
                beat_xi[k / 4][(k % 4) * 16 +: 16]  = x;
                if (k < n) y += longint'($signed(v)) * longint'($signed(x));
            end
            run_row($sformatf("rand%0d", r), n, y, 30, 30);
        end

        bus.s_times_tdata  = 32'd12;
        bus.s_times_tvalid = 1'b1;
        @(negedge clk);
        check("mid-row count", 64'(bus.s_times_tready), 64'd1);
        nxt();
        bus.s_times_tvalid = 1'b0;
        bus.s_val_tdata    = pack4(1, 2, 3, 4);
        bus.s_xi_tdata     = pack4(1, 1, 1, 1);
        bus.s_val_tvalid   = 1'b1;
        bus.s_xi_tvalid    = 1'b1;
        @(negedge clk);
        check("mid-row beat", 64'(bus.s_val_tready), 64'd1);
        nxt();
        rst = 1'b1;
        @(negedge clk);
        check("mid-row times ready in reset", 64'(bus.s_times_tready), 64'd0);
        nxt();
        rst = 1'b0;
        rows_exp = 0;
        @(negedge clk);
        check("post-reset y valid", 64'(bus.m_y_tvalid), 64'd0);
        check("post-reset y data", 64'(bus.m_y_tdata), 64'd0);
        check("post-reset beat ready", 64'(bus.s_val_tready | bus.s_xi_tready), 64'd0);
        check("post-reset times ready", 64'(bus.s_times_tready), 64'd1);
        check("post-reset rows_done", 64'(rows_done), 64'd0);
        check("post-reset sat_flag", 64'(sat_flag_s), 64'd0);
        nxt();
        bus.s_val_tvalid = 1'b0;
        bus.s_xi_tvalid  = 1'b0;
        beat_val[0] = pack4(2, 2, 2, 2);
        beat_xi[0]  = pack4(5, 5, 5, 5);
        run_row("fresh row", 4, 40, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end
endmodule
